// File: rtl/result_drain.sv
// Result drain: snapshots matrix C on start and streams it row-major over valid/ready,
// requantizing each element (rounding arithmetic shift, then signed saturation).
`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef A_M
`define A_M 2
`endif
`ifndef B_N
`define B_N 2
`endif

module result_drain #(
  parameter int DATA_W = `DATA_W,
  parameter int ROWS   = `A_M,
  parameter int COLS   = `B_N,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] matrix_C [ROWS*COLS],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [9:0]        out_row,
  output logic [9:0]        out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [DATA_W:0] RND = (DATA_W+1)'((64'd1 << SHIFT) >> 1);
  localparam logic signed [DATA_W:0] SAT_MAX = {{(DATA_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] SAT_MIN = {{(DATA_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, data/row/col/last are held unchanged.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q;
  logic [9:0]        row_q, col_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q, last_q, done_q;
  logic [DATA_W-1:0] buf_q [N];
  logic signed [DATA_W:0] ext_d, rnd_d, sh_d;
  logic [OUT_W-1:0]  sat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= STREAM;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= (N == 1);
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              // Counters return to zero so row/col read 0 outside the stream.
              state_q <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              row_q   <= '0;
              col_q   <= '0;
              idx_q   <= '0;
            end else begin
              idx_q  <= idx_q + 1'b1;
              last_q <= ((idx_q + 1'b1) == LAST_IDX);
              if (col_q == 10'(COLS - 1)) begin
                col_q <= '0;
                row_q <= row_q + 10'd1;
              end else begin
                col_q <= col_q + 10'd1;
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The snapshot is only taken from IDLE, so later changes on matrix_C are invisible.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      for (int i = 0; i < N; i++) buf_q[i] <= matrix_C[i];
    end
  end

  always_comb begin
    ext_d = {buf_q[idx_q][DATA_W-1], buf_q[idx_q]};
    rnd_d = ext_d + RND;
    sh_d  = rnd_d >>> SHIFT;
    if (sh_d > SAT_MAX)      sat_d = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sh_d < SAT_MIN) sat_d = {1'b1, {(OUT_W-1){1'b0}}};
    else                     sat_d = sh_d[OUT_W-1:0];
  end

  assign out_valid = valid_q;
  assign busy      = valid_q;
  assign out_data  = valid_q ? sat_d : '0;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign dbg_state = state_q;
endmodule
